// File: rtl/fft_stream_fifo.sv
// Synchronous FIFO between FFT pipeline stages: arbitrary depth, occupancy and threshold flags,
// one-cycle read-valid pulses. Define FFT_FIFO_ERR_EN to build the sticky overflow/underflow monitor.
module fft_stream_fifo #(
    parameter int DATA_WD = 10,
    parameter int DEPTH   = 3,
    parameter int AF_LVL  = DEPTH - 1,
    parameter int AE_LVL  = 1,
    localparam int PTR_WD = $clog2(DEPTH),
    localparam int LVL_WD = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_vld_i,
    input  logic [DATA_WD-1:0] wr_dat_i,
    output logic               wr_ful_o,
    output logic               wr_afl_o,
    input  logic               rd_vld_i,
    output logic               rd_vld_o,
    output logic [DATA_WD-1:0] rd_dat_o,
    output logic               rd_ept_o,
    output logic               rd_aep_o,
    output logic [LVL_WD-1:0]  lvl_o,
    input  logic               err_clr_i,
    output logic               ovf_o,
    output logic               udf_o
);

    logic [DATA_WD-1:0] mem_q [DEPTH];
    logic [PTR_WD-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_WD-1:0]  lvl_q, lvl_d;
    logic [DATA_WD-1:0] rd_dat_q;
    logic               rd_vld_q;
    logic               rd_acc, wr_acc;

    assign rd_ept_o = (lvl_q == '0);
    assign wr_ful_o = (lvl_q == LVL_WD'(DEPTH));
    assign wr_afl_o = (lvl_q >= LVL_WD'(AF_LVL));
    assign rd_aep_o = (lvl_q <= LVL_WD'(AE_LVL));
    assign lvl_o    = lvl_q;
    assign rd_vld_o = rd_vld_q;
    assign rd_dat_o = rd_dat_q;

    // No bypass: an empty FIFO rejects reads even when a write lands in the same cycle.
    assign rd_acc = rd_vld_i & ~rd_ept_o;
    assign wr_acc = wr_vld_i & (~wr_ful_o | rd_acc);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        lvl_d    = lvl_q;
        if (wr_acc)
            wr_ptr_d = (wr_ptr_q == PTR_WD'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_WD'(1);
        if (rd_acc)
            rd_ptr_d = (rd_ptr_q == PTR_WD'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_WD'(1);
        if (wr_acc && !rd_acc)
            lvl_d = lvl_q + LVL_WD'(1);
        else if (!wr_acc && rd_acc)
            lvl_d = lvl_q - LVL_WD'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            lvl_q    <= '0;
            rd_vld_q <= 1'b0;
            rd_dat_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            lvl_q    <= lvl_d;
            rd_vld_q <= rd_acc;
            if (rd_acc)
                rd_dat_q <= mem_q[rd_ptr_q];
        end
    end

    // Storage carries no reset; the level alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (wr_acc)
            mem_q[wr_ptr_q] <= wr_dat_i;
    end

`ifdef FFT_FIFO_ERR_EN
    logic ovf_q, udf_q, ovf_evt, udf_evt;

    assign ovf_evt = wr_vld_i & wr_ful_o & ~rd_acc;
    assign udf_evt = rd_vld_i & rd_ept_o;

    // A new event in the clearing cycle keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_evt | (ovf_q & ~err_clr_i);
            udf_q <= udf_evt | (udf_q & ~err_clr_i);
        end
    end

    assign ovf_o = ovf_q;
    assign udf_o = udf_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr_i;
    assign ovf_o = 1'b0;
    assign udf_o = 1'b0;
`endif

endmodule

// File: tb/tb_fft_stream_fifo.sv
// Randomized and directed bench for fft_stream_fifo against a queue-based reference model.
// Honours FFT_FIFO_ERR_EN the same way the design does.
module tb_fft_stream_fifo;

    localparam int DATA_WD = 10;
    localparam int DEPTH   = 3;
    localparam int AF_LVL  = DEPTH - 1;
    localparam int AE_LVL  = 1;
    localparam int LVL_WD  = $clog2(DEPTH + 1);

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               wr_vld_i = 1'b0;
    logic [DATA_WD-1:0] wr_dat_i = '0;
    logic               rd_vld_i = 1'b0;
    logic               err_clr_i = 1'b0;
    logic               wr_ful_o, wr_afl_o, rd_vld_o, rd_ept_o, rd_aep_o, ovf_o, udf_o;
    logic [DATA_WD-1:0] rd_dat_o;
    logic [LVL_WD-1:0]  lvl_o;

    fft_stream_fifo #(.DATA_WD(DATA_WD), .DEPTH(DEPTH), .AF_LVL(AF_LVL), .AE_LVL(AE_LVL)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_vld_i(wr_vld_i), .wr_dat_i(wr_dat_i), .wr_ful_o(wr_ful_o), .wr_afl_o(wr_afl_o),
        .rd_vld_i(rd_vld_i), .rd_vld_o(rd_vld_o), .rd_dat_o(rd_dat_o),
        .rd_ept_o(rd_ept_o), .rd_aep_o(rd_aep_o), .lvl_o(lvl_o),
        .err_clr_i(err_clr_i), .ovf_o(ovf_o), .udf_o(udf_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: the FIFO contents as a queue plus the registered read outputs.
    logic [DATA_WD-1:0] mq[$];
    logic               m_vld = 1'b0;
    logic [DATA_WD-1:0] m_dat = '0;
    logic               m_ovf = 1'b0;
    logic               m_udf = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_all();
        int n;
        n = mq.size();
        chk("lvl", 32'(lvl_o), 32'(n));
        chk("ept", 32'(rd_ept_o), 32'(n == 0));
        chk("aep", 32'(rd_aep_o), 32'(n <= AE_LVL));
        chk("ful", 32'(wr_ful_o), 32'(n == DEPTH));
        chk("afl", 32'(wr_afl_o), 32'(n >= AF_LVL));
        chk("rd_vld", 32'(rd_vld_o), 32'(m_vld));
        chk("rd_dat", 32'(rd_dat_o), 32'(m_dat));
        chk("ovf", 32'(ovf_o), 32'(m_ovf));
        chk("udf", 32'(udf_o), 32'(m_udf));
    endtask

    task automatic model_reset();
        mq.delete();
        m_vld = 1'b0;
        m_dat = '0;
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    // One clock cycle: drive on the falling edge, update the model at the rising edge, check after it.
    task automatic step(input bit wr, input logic [DATA_WD-1:0] d, input bit rd, input bit clr);
        bit racc, wacc, oev, uev;
        @(negedge clk);
        wr_vld_i  = wr;
        wr_dat_i  = d;
        rd_vld_i  = rd;
        err_clr_i = clr;
        racc = rd && (mq.size() > 0);
        wacc = wr && ((mq.size() < DEPTH) || racc);
        oev  = wr && (mq.size() == DEPTH) && !racc;
        uev  = rd && (mq.size() == 0);
        @(posedge clk);
        if (racc) begin
            m_dat = mq.pop_front();
            m_vld = 1'b1;
        end else begin
            m_vld = 1'b0;
        end
        if (wacc)
            mq.push_back(d);
`ifdef FFT_FIFO_ERR_EN
        m_ovf = oev ? 1'b1 : (clr ? 1'b0 : m_ovf);
        m_udf = uev ? 1'b1 : (clr ? 1'b0 : m_udf);
`else
        if (oev || uev || clr) begin end
`endif
        #1;
        chk_all();
        wr_vld_i  = 1'b0;
        rd_vld_i  = 1'b0;
        err_clr_i = 1'b0;
    endtask

    initial begin
        // Reset state, checked while reset is held.
        #2;
        model_reset();
        chk_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Fill to full, then drain.
        step(1, 10'h001, 0, 0);
        step(1, 10'h002, 0, 0);
        step(1, 10'h003, 0, 0);
        step(0, 10'h000, 1, 0);
        step(0, 10'h000, 1, 0);
        step(0, 10'h000, 1, 0);
        step(0, 10'h000, 0, 0);

        // Full FIFO with simultaneous write and read.
        for (int i = 0; i < 3; i++) step(1, 10'(i + 16), 0, 0);
        step(1, 10'h3FF, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 10'h000, 1, 0);

        // Empty FIFO with simultaneous write and read: read rejected.
        step(1, 10'h055, 1, 0);
        step(0, 10'h000, 1, 0);
        step(0, 10'h000, 0, 1);

        // Pointer wrap with write-then-read pairs.
        for (int i = 0; i < 10; i++) begin
            step(1, 10'(i), 0, 0);
            step(0, 10'h000, 1, 0);
        end

        // Overflow, clear, and clear colliding with a new overflow.
        for (int i = 0; i < 3; i++) step(1, 10'(i + 32), 0, 0);
        step(1, 10'h111, 0, 0);
        step(0, 10'h000, 0, 1);
        step(1, 10'h222, 0, 1);
        step(0, 10'h000, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 10'h000, 1, 0);

        // Asynchronous reset mid-operation with level 2 and rd_vld_o high.
        for (int i = 0; i < 3; i++) step(1, 10'(i + 48), 0, 0);
        step(0, 10'h000, 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_all();
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 10'h000, 1, 0);
        step(1, 10'h0AA, 0, 1);
        step(0, 10'h000, 1, 0);

        // Randomized traffic with varying write/read pressure.
        for (int blk = 0; blk < 6; blk++) begin
            int pw, pr;
            pw = $urandom_range(20, 80);
            pr = $urandom_range(20, 80);
            for (int i = 0; i < 100; i++)
                step($urandom_range(0, 99) < pw, 10'($urandom), $urandom_range(0, 99) < pr,
                     $urandom_range(0, 15) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
